// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-controller Wishbone arbiter with round-robin on contention and no preemption.
// Defining WB_ARB_TIMEOUT_EN adds a stall timeout that force-acks a stuck owner and sets sticky timeout_o.
module wb_arbiter2 #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       m0_wb_cyc_i,
    input  logic       m0_wb_stb_i,
    input  logic       m0_wb_we_i,
    input  logic [3:0] m0_wb_adr_i,
    input  logic [7:0] m0_wb_dat_i,
    output logic [7:0] m0_wb_dat_o,
    output logic       m0_wb_ack_o,
    input  logic       m1_wb_cyc_i,
    input  logic       m1_wb_stb_i,
    input  logic       m1_wb_we_i,
    input  logic [3:0] m1_wb_adr_i,
    input  logic [7:0] m1_wb_dat_i,
    output logic [7:0] m1_wb_dat_o,
    output logic       m1_wb_ack_o,
    output logic       p_wb_cyc_o,
    output logic       p_wb_stb_o,
    output logic       p_wb_we_o,
    output logic [3:0] p_wb_adr_o,
    output logic [7:0] p_wb_dat_o,
    input  logic [7:0] p_wb_dat_i,
    input  logic       p_wb_ack_i,
    output logic       timeout_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   last_q, last_d;
    logic   hit_s;

    // State and round-robin pointer register; reset makes m0 win the first contention
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Next-state: the owner keeps the bus while its cyc is high, then hands over without a bubble
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (m0_wb_cyc_i && m1_wb_cyc_i) begin
                    state_d = last_q ? OWN0 : OWN1;
                end else if (m0_wb_cyc_i) begin
                    state_d = OWN0;
                end else if (m1_wb_cyc_i) begin
                    state_d = OWN1;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN0: begin
                if (m0_wb_cyc_i) begin
                    state_d = OWN0;
                end else if (m1_wb_cyc_i) begin
                    state_d = OWN1;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN1: begin
                if (m1_wb_cyc_i) begin
                    state_d = OWN1;
                end else if (m0_wb_cyc_i) begin
                    state_d = OWN0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pointer tracks the controller granted next; staying in OWNN leaves it at N already
    always_comb begin
        last_d = last_q;
        case (state_d)
            OWN0:    last_d = 1'b0;
            OWN1:    last_d = 1'b1;
            default: last_d = last_q;
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;
    logic       stall_s;

    // Stall counter: the TIMEOUT_CYCLES-th consecutive stalled owner cycle is the one that fires
    always_comb begin
        stall_s = 1'b0;
        case (state_q)
            OWN0:    stall_s = m0_wb_stb_i & ~p_wb_ack_i;
            OWN1:    stall_s = m1_wb_stb_i & ~p_wb_ack_i;
            default: stall_s = 1'b0;
        endcase
        hit_s = stall_s && (cnt_q == CNT_LAST);
        if (hit_s || !stall_s || (state_d != state_q)) begin
            cnt_d = 8'd0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
        timeout_d = timeout_q | hit_s;
    end

    // Counter and sticky flag register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    logic unused_cfg_s;

    assign unused_cfg_s = ^8'(TIMEOUT_CYCLES);
    assign hit_s        = 1'b0;
    assign timeout_o    = 1'b0;
`endif

    // Output mux: owner sees the peripheral, everyone else sees zeros
    always_comb begin
        p_wb_cyc_o  = 1'b0;
        p_wb_stb_o  = 1'b0;
        p_wb_we_o   = 1'b0;
        p_wb_adr_o  = 4'h0;
        p_wb_dat_o  = 8'h00;
        m0_wb_dat_o = 8'h00;
        m0_wb_ack_o = 1'b0;
        m1_wb_dat_o = 8'h00;
        m1_wb_ack_o = 1'b0;
        case (state_q)
            OWN0: begin
                p_wb_cyc_o  = m0_wb_cyc_i;
                p_wb_stb_o  = m0_wb_stb_i & ~hit_s;
                p_wb_we_o   = m0_wb_we_i;
                p_wb_adr_o  = m0_wb_adr_i;
                p_wb_dat_o  = m0_wb_dat_i;
                m0_wb_dat_o = hit_s ? 8'h00 : p_wb_dat_i;
                m0_wb_ack_o = (p_wb_ack_i & m0_wb_stb_i) | hit_s;
            end
            OWN1: begin
                p_wb_cyc_o  = m1_wb_cyc_i;
                p_wb_stb_o  = m1_wb_stb_i & ~hit_s;
                p_wb_we_o   = m1_wb_we_i;
                p_wb_adr_o  = m1_wb_adr_i;
                p_wb_dat_o  = m1_wb_dat_i;
                m1_wb_dat_o = hit_s ? 8'h00 : p_wb_dat_i;
                m1_wb_ack_o = (p_wb_ack_i & m1_wb_stb_i) | hit_s;
            end
            default: begin
                p_wb_cyc_o  = 1'b0;
                m0_wb_ack_o = 1'b0;
                m1_wb_ack_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: handover, round-robin, read/write paths, async reset, stall timeout.
module tb_wb_arbiter2;

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic EXP_TO = 1'b1;
`else
    localparam logic EXP_TO = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       m0_wb_cyc_i, m0_wb_stb_i, m0_wb_we_i;
    logic [3:0] m0_wb_adr_i;
    logic [7:0] m0_wb_dat_i, m0_wb_dat_o;
    logic       m0_wb_ack_o;
    logic       m1_wb_cyc_i, m1_wb_stb_i, m1_wb_we_i;
    logic [3:0] m1_wb_adr_i;
    logic [7:0] m1_wb_dat_i, m1_wb_dat_o;
    logic       m1_wb_ack_o;
    logic       p_wb_cyc_o, p_wb_stb_o, p_wb_we_o;
    logic [3:0] p_wb_adr_o;
    logic [7:0] p_wb_dat_o, p_wb_dat_i;
    logic       p_wb_ack_i;
    logic       timeout_o;

    int vectors;
    int miscompares;

    wb_arbiter2 #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .m0_wb_cyc_i (m0_wb_cyc_i),
        .m0_wb_stb_i (m0_wb_stb_i),
        .m0_wb_we_i  (m0_wb_we_i),
        .m0_wb_adr_i (m0_wb_adr_i),
        .m0_wb_dat_i (m0_wb_dat_i),
        .m0_wb_dat_o (m0_wb_dat_o),
        .m0_wb_ack_o (m0_wb_ack_o),
        .m1_wb_cyc_i (m1_wb_cyc_i),
        .m1_wb_stb_i (m1_wb_stb_i),
        .m1_wb_we_i  (m1_wb_we_i),
        .m1_wb_adr_i (m1_wb_adr_i),
        .m1_wb_dat_i (m1_wb_dat_i),
        .m1_wb_dat_o (m1_wb_dat_o),
        .m1_wb_ack_o (m1_wb_ack_o),
        .p_wb_cyc_o  (p_wb_cyc_o),
        .p_wb_stb_o  (p_wb_stb_o),
        .p_wb_we_o   (p_wb_we_o),
        .p_wb_adr_o  (p_wb_adr_o),
        .p_wb_dat_o  (p_wb_dat_o),
        .p_wb_dat_i  (p_wb_dat_i),
        .p_wb_ack_i  (p_wb_ack_i),
        .timeout_o   (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_ni      = 1'b0;
        m0_wb_cyc_i = 1'b0; m0_wb_stb_i = 1'b0; m0_wb_we_i = 1'b0;
        m0_wb_adr_i = 4'h0; m0_wb_dat_i = 8'h00;
        m1_wb_cyc_i = 1'b0; m1_wb_stb_i = 1'b0; m1_wb_we_i = 1'b0;
        m1_wb_adr_i = 4'h0; m1_wb_dat_i = 8'h00;
        p_wb_dat_i  = 8'h00; p_wb_ack_i = 1'b0;
        #3;
        chk1("rst_p_cyc", p_wb_cyc_o, 1'b0);
        chk1("rst_m0_ack", m0_wb_ack_o, 1'b0);
        chk1("rst_timeout", timeout_o, 1'b0);

        // Contention right after reset, handover, round-robin return
        next_cycle();
        rst_ni = 1'b1;
        m0_wb_cyc_i = 1'b1; m0_wb_stb_i = 1'b1; m0_wb_adr_i = 4'h1;
        m1_wb_cyc_i = 1'b1; m1_wb_stb_i = 1'b1; m1_wb_adr_i = 4'h9;
        #2;
        chk1("idle_p_cyc", p_wb_cyc_o, 1'b0);
        next_cycle(); #2;
        chk4("rr_first_own0_adr", p_wb_adr_o, 4'h1);
        chk1("rr_first_own0_cyc", p_wb_cyc_o, 1'b1);
        next_cycle();
        m0_wb_cyc_i = 1'b0; m0_wb_stb_i = 1'b0;
        #2;
        chk4("own0_after_drop_adr", p_wb_adr_o, 4'h1);
        chk1("own0_after_drop_cyc", p_wb_cyc_o, 1'b0);
        next_cycle();
        p_wb_ack_i = 1'b1;
        #2;
        chk4("handoff_own1_adr", p_wb_adr_o, 4'h9);
        chk1("handoff_m1_ack", m1_wb_ack_o, 1'b1);
        chk1("handoff_m0_ack", m0_wb_ack_o, 1'b0);
        next_cycle();
        m1_wb_cyc_i = 1'b0; m1_wb_stb_i = 1'b0; p_wb_ack_i = 1'b0;
        next_cycle();
        m0_wb_cyc_i = 1'b1; m0_wb_stb_i = 1'b1;
        m1_wb_cyc_i = 1'b1; m1_wb_stb_i = 1'b1;
        #2;
        chk1("idle_after_release", p_wb_cyc_o, 1'b0);
        next_cycle(); #2;
        chk4("rr_return_own0", p_wb_adr_o, 4'h1);
        next_cycle();
        m0_wb_cyc_i = 1'b0; m0_wb_stb_i = 1'b0;
        m1_wb_cyc_i = 1'b0; m1_wb_stb_i = 1'b0;
        next_cycle();

        // Single m0 write from IDLE
        m0_wb_cyc_i = 1'b1; m0_wb_stb_i = 1'b1; m0_wb_we_i = 1'b1;
        m0_wb_adr_i = 4'h2; m0_wb_dat_i = 8'hA5;
        #2;
        chk1("wr_idle_stb", p_wb_stb_o, 1'b0);
        next_cycle();
        p_wb_ack_i = 1'b1;
        #2;
        chk1("wr_p_stb", p_wb_stb_o, 1'b1);
        chk1("wr_p_we", p_wb_we_o, 1'b1);
        chk4("wr_p_adr", p_wb_adr_o, 4'h2);
        chk8("wr_p_dat", p_wb_dat_o, 8'hA5);
        chk1("wr_m0_ack", m0_wb_ack_o, 1'b1);
        chk1("wr_m1_ack", m1_wb_ack_o, 1'b0);
        next_cycle();
        m0_wb_cyc_i = 1'b0; m0_wb_stb_i = 1'b0; m0_wb_we_i = 1'b0;
        m0_wb_dat_i = 8'h00; p_wb_ack_i = 1'b0;
        next_cycle();

        // m1 read while m0 waits (pointer now 0, so m1 wins)
        m1_wb_cyc_i = 1'b1; m1_wb_stb_i = 1'b1; m1_wb_adr_i = 4'h7;
        m0_wb_cyc_i = 1'b1; m0_wb_stb_i = 1'b1; m0_wb_adr_i = 4'h3;
        next_cycle();
        p_wb_dat_i = 8'h3C; p_wb_ack_i = 1'b1;
        #2;
        chk8("rd_m1_dat", m1_wb_dat_o, 8'h3C);
        chk1("rd_m1_ack", m1_wb_ack_o, 1'b1);
        chk8("rd_m0_dat", m0_wb_dat_o, 8'h00);
        chk1("rd_m0_ack", m0_wb_ack_o, 1'b0);
        chk4("rd_p_adr", p_wb_adr_o, 4'h7);
        chk1("rd_p_we", p_wb_we_o, 1'b0);
        next_cycle();
        m1_wb_stb_i = 1'b0;
        #2;
        chk1("rd_m1_ack_stb_low", m1_wb_ack_o, 1'b0);
        chk1("rd_m0_ack_wait", m0_wb_ack_o, 1'b0);
        next_cycle();
        m1_wb_cyc_i = 1'b0;
        #2;
        chk1("rd_m0_ack_last_own1", m0_wb_ack_o, 1'b0);
        next_cycle(); #2;
        chk8("rd_m0_dat_own0", m0_wb_dat_o, 8'h3C);
        chk1("rd_m0_ack_own0", m0_wb_ack_o, 1'b1);
        chk8("rd_m1_dat_own0", m1_wb_dat_o, 8'h00);
        chk4("rd_p_adr_own0", p_wb_adr_o, 4'h3);
        next_cycle();
        m0_wb_cyc_i = 1'b0; m0_wb_stb_i = 1'b0;
        p_wb_ack_i = 1'b0; p_wb_dat_i = 8'h00;
        next_cycle();

        // Asynchronous reset in the middle of an OWN1 transfer
        m1_wb_cyc_i = 1'b1; m1_wb_stb_i = 1'b1; m1_wb_adr_i = 4'h9;
        next_cycle(); #2;
        chk1("pre_rst_own1_cyc", p_wb_cyc_o, 1'b1);
        chk4("pre_rst_own1_adr", p_wb_adr_o, 4'h9);
        p_wb_ack_i = 1'b1; p_wb_dat_i = 8'h5A;
        #1;
        rst_ni = 1'b0;
        #1;
        chk1("mid_rst_p_cyc", p_wb_cyc_o, 1'b0);
        chk1("mid_rst_p_stb", p_wb_stb_o, 1'b0);
        chk4("mid_rst_p_adr", p_wb_adr_o, 4'h0);
        chk1("mid_rst_m1_ack", m1_wb_ack_o, 1'b0);
        chk8("mid_rst_m1_dat", m1_wb_dat_o, 8'h00);
        next_cycle();
        m0_wb_cyc_i = 1'b1; m0_wb_stb_i = 1'b1; m0_wb_adr_i = 4'h1;
        p_wb_ack_i = 1'b0; p_wb_dat_i = 8'h00;
        next_cycle();
        rst_ni = 1'b1;
        #2;
        chk1("post_rst_idle", p_wb_cyc_o, 1'b0);
        next_cycle(); #2;
        chk4("post_rst_m0_wins", p_wb_adr_o, 4'h1);
        next_cycle();
        m0_wb_cyc_i = 1'b0; m0_wb_stb_i = 1'b0;
        m1_wb_cyc_i = 1'b0; m1_wb_stb_i = 1'b0;
        next_cycle();

        // Stall: peripheral never acks
        m0_wb_cyc_i = 1'b1; m0_wb_stb_i = 1'b1; m0_wb_adr_i = 4'h5;
        p_wb_dat_i = 8'hFF; p_wb_ack_i = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            next_cycle(); #2;
            chk1("stall_p_stb", p_wb_stb_o, 1'b1);
            chk1("stall_m0_ack", m0_wb_ack_o, 1'b0);
        end
        next_cycle(); #2;
        chk1("to_p_stb", p_wb_stb_o, ~EXP_TO);
        chk1("to_m0_ack", m0_wb_ack_o, EXP_TO);
        chk8("to_m0_dat", m0_wb_dat_o, EXP_TO ? 8'h00 : 8'hFF);
        chk1("to_flag_same_cycle", timeout_o, 1'b0);
        next_cycle(); #2;
        chk1("to_flag_set", timeout_o, EXP_TO);
        chk1("to_m0_ack_after", m0_wb_ack_o, 1'b0);
        chk1("to_p_stb_after", p_wb_stb_o, 1'b1);
        next_cycle();
        m0_wb_cyc_i = 1'b0; m0_wb_stb_i = 1'b0;
        next_cycle(); #2;
        chk1("to_flag_sticky", timeout_o, EXP_TO);
        rst_ni = 1'b0;
        #1;
        chk1("to_flag_rst", timeout_o, 1'b0);
        next_cycle();
        rst_ni = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_arbiter2.md
WB_ARBITER2 -- requirements
Module: wb_arbiter2

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the stall limit in cycles (legal 1..255), used only when WB_ARB_TIMEOUT_EN is defined.
REQ-002 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports m0_wb_cyc_i, m1_wb_cyc_i  input  1  controller bus request/hold.
REQ-005 SHALL have ports m0_wb_stb_i, m1_wb_stb_i  input  1  controller strobe.
REQ-006 SHALL have ports m0_wb_we_i, m1_wb_we_i  input  1  controller write enable.
REQ-007 SHALL have ports m0_wb_adr_i, m1_wb_adr_i  input  4  controller address.
REQ-008 SHALL have ports m0_wb_dat_i, m1_wb_dat_i  input  8  controller write data.
REQ-009 SHALL have ports m0_wb_dat_o, m1_wb_dat_o  output  8  read data to controller.
REQ-010 SHALL have ports m0_wb_ack_o, m1_wb_ack_o  output  1  ack to controller.
REQ-011 SHALL have ports p_wb_cyc_o, p_wb_stb_o, p_wb_we_o  output  1 each  shared peripheral bus controls.
REQ-012 SHALL have ports p_wb_adr_o  output  4, p_wb_dat_o  output  8, p_wb_dat_i  input  8, p_wb_ack_i  input  1  shared peripheral bus.
REQ-013 SHALL have port timeout_o  output  1  sticky stall-timeout flag.

Function
REQ-014 SHALL implement a registered state machine with states IDLE, OWN0, OWN1, plus a 1-bit round-robin pointer last_q naming the last-served controller.
REQ-015 In IDLE, with exactly one mN_wb_cyc_i high, the next state SHALL be OWNN.
REQ-016 In IDLE, with both cyc inputs high, the next state SHALL grant the controller other than last_q.
REQ-017 On every entry to OWNN, last_q SHALL be set to N.
REQ-018 In OWNN, the grant SHALL hold while mN_wb_cyc_i is high; no preemption.
REQ-019 In OWNN, when mN_wb_cyc_i is low and the other cyc is high, the next state SHALL be the other OWN state directly (no bubble).
REQ-020 In OWNN, when both cyc inputs are low, the next state SHALL be IDLE.
REQ-021 In OWNN, p_wb_* outputs SHALL combinationally mirror controller N's cyc/stb/we/adr/dat.
REQ-022 In OWNN, mN_wb_dat_o SHALL equal p_wb_dat_i and mN_wb_ack_o SHALL equal p_wb_ack_i AND mN_wb_stb_i.
REQ-023 The non-owner's ack and dat outputs, and all p_wb_* outputs in IDLE, SHALL be 0.
REQ-024 Latency SHALL be: cyc+stb asserted in IDLE at cycle n -> p_wb_stb_o high in cycle n+1; with a same-cycle peripheral ack, controller ack in n+1; an already-granted controller SHALL see zero added latency.
REQ-025 The block SHALL never assert an ack to a controller whose stb is low, and SHALL never drive two grants at once.

Reset
REQ-026 rst_ni low SHALL asynchronously force state IDLE, last_q=1 (m0 wins first contention), timeout_o=0 and timeout counter 0.
REQ-027 Consequently all outputs SHALL read 0 during reset, including when reset is asserted mid-transfer; an in-flight transfer SHALL be abandoned without ack.
REQ-028 Reset release SHALL be sampled at clk_i rising edge; arbitration SHALL begin at the first edge after release.

Configuration
REQ-029 Macro WB_ARB_TIMEOUT_EN defined: an 8-bit counter SHALL count the owner's consecutive cycles with stb high and p_wb_ack_i low, clearing on ack, stb low or grant change.
REQ-030 With the macro defined, when the counter reaches TIMEOUT_CYCLES, that cycle SHALL suppress p_wb_stb_o, drive a one-cycle owner ack with dat_o=0, set timeout_o, and clear the counter.
REQ-031 With the macro defined, timeout_o SHALL clear only by reset.
REQ-032 Macro undefined: no counter SHALL exist, timeout_o SHALL be constant 0, and stalls SHALL wait indefinitely.

Verification
REQ-033 Bench SHALL cover single m0 write adr=4'h2 dat=8'hA5 from IDLE with peripheral ack = stb -> p_wb_stb_o/we_o high at cycle n+1 with adr 2, dat A5; m0 ack at n+1; m1 ack stays 0.
REQ-034 Bench SHALL cover both cyc high first cycle after reset -> OWN0; m0 drops cyc while m1 holds -> OWN1 next edge; both release, then re-request -> OWN0 (round-robin).
REQ-035 Bench SHALL cover m1 read with p_wb_dat_i=8'h3C while m0 requests -> m1_wb_dat_o=3C with ack; m0_wb_dat_o=0, m0 ack 0 until m1 releases cyc.
REQ-036 Bench SHALL cover rst_ni pulsed low mid-transfer in OWN1 -> all outputs 0 immediately (asynchronously), no ack; after release, m0 wins contention.
REQ-037 Bench SHALL cover, with WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, p_wb_ack_i held 0 with m0 stb high -> m0 ack with dat 0 on the 4th stalled cycle, p_wb_stb_o low that cycle, timeout_o=1 until reset; without the macro, no ack and timeout_o=0.
